xcvr_ctrl_multi: RTL and testbench

//  Multi-channel transceiver bring-up sequencer on one shared reconfig Avalon-MM master. After PLL lock it walks

---
 rtl/xcvr_ctrl_multi.sv | 195 +++++++++++++++++++
 tb/tb_xcvr_ctrl_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_ctrl_multi.sv
// Multi-channel transceiver bring-up sequencer: after PLL lock it walks every channel through
// PMA config load, initial adaptation and optional continuous adaptation over one reconfig Avalon-MM master.
module xcvr_ctrl_multi #(
    parameter int CH_COUNT     = 4,
    parameter int CH_W         = 2,
    parameter int START_DELAY  = 65535,
    parameter int POLL_TIMEOUT = 4095,
    parameter int MAX_RETRIES  = 3,
    parameter int CONT_ADAPT   = 1
) (
    input  logic                reconfig_clk,
    input  logic                reconfig_rst,
    input  logic                pll_locked_in,
    input  logic                restart,
    output logic [CH_W+18:0]    xcvr_reconfig_address,
    output logic                xcvr_reconfig_read,
    output logic                xcvr_reconfig_write,
    input  logic [7:0]          xcvr_reconfig_readdata,
    output logic [7:0]          xcvr_reconfig_writedata,
    input  logic                xcvr_reconfig_waitrequest,
    output logic [CH_COUNT-1:0] ch_done,
    output logic [CH_COUNT-1:0] ch_fail,
    output logic                busy,
    output logic [4:0]          state_dbg
);

    localparam int RT_W = 8;

    typedef enum logic [4:0] {
        S_IDLE, S_START_WAIT, S_LOAD_PMA, S_PMA_POLL,
        S_INIT_W0, S_INIT_W1, S_INIT_W2, S_INIT_W3, S_INIT_POLL,
        S_CONT_W0, S_CONT_W1, S_CONT_W2, S_CONT_W3, S_CONT_POLL,
        S_NEXT_CH, S_DONE
    } state_t;

    state_t          state, state_nxt, poll_fail_nxt;
    logic [2:0]      lock_sync;
    logic            locked;
    logic            cmd_active, accept, abort, last_ch;
    logic            is_write, is_poll, poll_ok, poll_eval, poll_expired, retry_left;
    logic            issue_rd, issue_wr;
    logic [18:0]     cmd_addr;
    logic [7:0]      cmd_data;
    logic [15:0]     delay_cnt;
    logic [11:0]     poll_cnt;
    logic [RT_W-1:0] retry_cnt;
    logic [CH_W-1:0] ch_idx;
    logic [7:0]      rdata_q;
    logic            rd_valid;

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_rst) lock_sync <= '0;
        else              lock_sync <= {lock_sync[1:0], pll_locked_in};
    end
    assign locked = lock_sync[2];

    // Handshake: read or write is raised with address/writedata and held unchanged while
    // waitrequest is high; the cycle with strobe && !waitrequest is the accept, strobe drops next cycle.
    assign cmd_active   = xcvr_reconfig_read | xcvr_reconfig_write;
    assign accept       = cmd_active & ~xcvr_reconfig_waitrequest;
    assign abort        = (state != S_IDLE) & (~locked | restart);
    assign last_ch      = (ch_idx == CH_W'(CH_COUNT - 1));
    assign poll_eval    = is_poll & rd_valid;
    assign poll_expired = poll_eval & ~poll_ok & (poll_cnt >= 12'(POLL_TIMEOUT));
    assign retry_left   = (retry_cnt < RT_W'(MAX_RETRIES));
    assign poll_fail_nxt = retry_left ? S_LOAD_PMA : S_NEXT_CH;

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_rst) state <= S_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (locked && !cmd_active) state_nxt = S_START_WAIT;
                S_START_WAIT: if (delay_cnt == '0) state_nxt = S_LOAD_PMA;
                S_LOAD_PMA:   if (accept) state_nxt = S_PMA_POLL;
                S_PMA_POLL: begin
                    if (poll_eval && poll_ok) state_nxt = S_INIT_W0;
                    else if (poll_expired)    state_nxt = poll_fail_nxt;
                end
                S_INIT_W0:    if (accept) state_nxt = S_INIT_W1;
                S_INIT_W1:    if (accept) state_nxt = S_INIT_W2;
                S_INIT_W2:    if (accept) state_nxt = S_INIT_W3;
                S_INIT_W3:    if (accept) state_nxt = S_INIT_POLL;
                S_INIT_POLL: begin
                    if (poll_eval && poll_ok) state_nxt = (CONT_ADAPT != 0) ? S_CONT_W0 : S_NEXT_CH;
                    else if (poll_expired)    state_nxt = poll_fail_nxt;
                end
                S_CONT_W0:    if (accept) state_nxt = S_CONT_W1;
                S_CONT_W1:    if (accept) state_nxt = S_CONT_W2;
                S_CONT_W2:    if (accept) state_nxt = S_CONT_W3;
                S_CONT_W3:    if (accept) state_nxt = S_CONT_POLL;
                S_CONT_POLL: begin
                    if (poll_eval && poll_ok) state_nxt = S_NEXT_CH;
                    else if (poll_expired)    state_nxt = poll_fail_nxt;
                end
                S_NEXT_CH:    state_nxt = last_ch ? S_DONE : S_LOAD_PMA;
                S_DONE:       state_nxt = S_DONE;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        is_write = 1'b0;
        is_poll  = 1'b0;
        poll_ok  = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        case (state)
            S_LOAD_PMA:  begin is_write = 1'b1; cmd_addr = 19'h40143; cmd_data = 8'h80; end
            S_PMA_POLL:  begin is_poll = 1'b1; cmd_addr = 19'h40144; poll_ok = rdata_q[0]; end
            S_INIT_W0:   begin is_write = 1'b1; cmd_addr = 19'h00200; cmd_data = 8'hD2; end
            S_INIT_W1:   begin is_write = 1'b1; cmd_addr = 19'h00201; cmd_data = 8'h02; end
            S_INIT_W2:   begin is_write = 1'b1; cmd_addr = 19'h00202; cmd_data = 8'h01; end
            S_INIT_W3:   begin is_write = 1'b1; cmd_addr = 19'h00203; cmd_data = 8'h96; end
            S_CONT_W0:   begin is_write = 1'b1; cmd_addr = 19'h00200; cmd_data = 8'hF6; end
            S_CONT_W1:   begin is_write = 1'b1; cmd_addr = 19'h00201; cmd_data = 8'h01; end
            S_CONT_W2:   begin is_write = 1'b1; cmd_addr = 19'h00202; cmd_data = 8'h03; end
            S_CONT_W3:   begin is_write = 1'b1; cmd_addr = 19'h00203; cmd_data = 8'h96; end
            S_INIT_POLL,
            S_CONT_POLL: begin is_poll = 1'b1; cmd_addr = 19'h00207; poll_ok = (rdata_q == 8'h80); end
            default: ;
        endcase
        // A poll re-reads only after the previous result has been evaluated.
        issue_wr = is_write & ~cmd_active & ~abort;
        issue_rd = is_poll & ~cmd_active & ~rd_valid & ~abort;
    end

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign state_dbg = state;

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_rst) begin
            xcvr_reconfig_read      <= 1'b0;
            xcvr_reconfig_write     <= 1'b0;
            xcvr_reconfig_address   <= '0;
            xcvr_reconfig_writedata <= '0;
            rd_valid                <= 1'b0;
            rdata_q                 <= '0;
        end else begin
            if (accept) begin
                xcvr_reconfig_read  <= 1'b0;
                xcvr_reconfig_write <= 1'b0;
            end else if (issue_rd) begin
                xcvr_reconfig_read    <= 1'b1;
                xcvr_reconfig_address <= {ch_idx, cmd_addr};
            end else if (issue_wr) begin
                xcvr_reconfig_write     <= 1'b1;
                xcvr_reconfig_address   <= {ch_idx, cmd_addr};
                xcvr_reconfig_writedata <= cmd_data;
            end
            // Only a read accepted inside a poll state produces a result to evaluate.
            rd_valid <= accept & xcvr_reconfig_read & is_poll;
            if (accept && xcvr_reconfig_read) rdata_q <= xcvr_reconfig_readdata;
        end
    end

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_rst) begin
            delay_cnt <= '0;
            poll_cnt  <= '0;
            retry_cnt <= '0;
            ch_idx    <= '0;
        end else begin
            if (state == S_IDLE)                               delay_cnt <= 16'(START_DELAY);
            else if (state == S_START_WAIT && delay_cnt != '0) delay_cnt <= delay_cnt - 16'd1;

            if (!is_poll)                             poll_cnt <= '0;
            else if (accept && xcvr_reconfig_read)    poll_cnt <= poll_cnt + 12'd1;

            if (state == S_IDLE || state == S_NEXT_CH)        retry_cnt <= '0;
            else if (poll_expired && retry_left && !abort)    retry_cnt <= retry_cnt + 1'b1;

            if (state == S_IDLE)                               ch_idx <= '0;
            else if (state == S_NEXT_CH && !last_ch && !abort) ch_idx <= ch_idx + 1'b1;
        end
    end

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_rst || abort || state == S_IDLE) begin
            ch_done <= '0;
            ch_fail <= '0;
        end else begin
            if (poll_expired && !retry_left)         ch_fail[ch_idx] <= 1'b1;
            if (state == S_NEXT_CH && !ch_fail[ch_idx]) ch_done[ch_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xcvr_ctrl_multi.sv
// Directed bench for xcvr_ctrl_multi: a command scoreboard checks every accepted bus transaction
// of dut_a in order; dut_b covers the no-continuous-adaptation build.
module tb_xcvr_ctrl_multi;

    localparam int AW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, lock_a, restart_a, lock_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          rd_a, wr_a, rd_b, wr_b, wait_a;
    logic [7:0]    wdata_a, wdata_b, rdata_a, rdata_b;
    logic [1:0]    done_a, fail_a, done_b, fail_b;
    logic          busy_a, busy_b;
    logic [4:0]    st_a, st_b;

    int n_cmp = 0, n_fail = 0;
    int stall_n = 0, stall_cnt = 0;
    int nwr_b = 0, nrd_b = 0, nf6_b = 0;
    logic fail_ch1 = 1'b0;
    logic prev_stall = 1'b0;
    logic [29:0] prev_cmd = '0;
    logic [28:0] exp_q[$];

    xcvr_ctrl_multi #(.CH_COUNT(2), .CH_W(1), .START_DELAY(4), .POLL_TIMEOUT(8),
                      .MAX_RETRIES(2), .CONT_ADAPT(1)) dut_a (
        .reconfig_clk(clk), .reconfig_rst(rst), .pll_locked_in(lock_a), .restart(restart_a),
        .xcvr_reconfig_address(addr_a), .xcvr_reconfig_read(rd_a), .xcvr_reconfig_write(wr_a),
        .xcvr_reconfig_readdata(rdata_a), .xcvr_reconfig_writedata(wdata_a),
        .xcvr_reconfig_waitrequest(wait_a), .ch_done(done_a), .ch_fail(fail_a),
        .busy(busy_a), .state_dbg(st_a));

    xcvr_ctrl_multi #(.CH_COUNT(2), .CH_W(1), .START_DELAY(4), .POLL_TIMEOUT(8),
                      .MAX_RETRIES(2), .CONT_ADAPT(0)) dut_b (
        .reconfig_clk(clk), .reconfig_rst(rst), .pll_locked_in(lock_b), .restart(1'b0),
        .xcvr_reconfig_address(addr_b), .xcvr_reconfig_read(rd_b), .xcvr_reconfig_write(wr_b),
        .xcvr_reconfig_readdata(rdata_b), .xcvr_reconfig_writedata(wdata_b),
        .xcvr_reconfig_waitrequest(1'b0), .ch_done(done_b), .ch_fail(fail_b),
        .busy(busy_b), .state_dbg(st_b));

    // Slave model: PMA status ready, adaptation status 0x80 unless ch1 is forced to fail.
    function automatic logic [7:0] slave_data(input logic [AW-1:0] a, input logic f);
        if (a[18:0] == 19'h40144) return 8'h01;
        if (a[18:0] == 19'h00207) return (f && a[19]) ? 8'h00 : 8'h80;
        return 8'h00;
    endfunction

    assign rdata_a = slave_data(addr_a, fail_ch1);
    assign rdata_b = slave_data(addr_b, 1'b0);
    assign wait_a  = (rd_a || wr_a) && (stall_cnt < stall_n);

    always @(posedge clk) begin
        if ((rd_a || wr_a) && wait_a) stall_cnt <= stall_cnt + 1;
        else                          stall_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted dut_a command must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && (rd_a || wr_a) && !wait_a) begin
            check("cmd_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("cmd", {rd_a, addr_a, (rd_a ? 8'h00 : wdata_a)}, exp_q.pop_front());
        end
        if (!rst && prev_stall) check("stall_hold", {rd_a, wr_a, addr_a, wdata_a}, prev_cmd);
        prev_stall <= (rd_a || wr_a) && wait_a;
        prev_cmd   <= {rd_a, wr_a, addr_a, wdata_a};
    end

    always @(negedge clk) begin
        if (!rst && wr_b) begin
            nwr_b <= nwr_b + 1;
            if (addr_b[18:0] == 19'h00200 && wdata_b == 8'hF6) nf6_b <= nf6_b + 1;
        end
        if (!rst && rd_b) nrd_b <= nrd_b + 1;
    end

    task automatic push_cmd(input logic r, input logic ch, input logic [18:0] a, input logic [7:0] d);
        exp_q.push_back({r, ch, a, d});
    endtask

    task automatic push_attempt(input logic ch, input int init_reads);
        push_cmd(1'b0, ch, 19'h40143, 8'h80);
        push_cmd(1'b1, ch, 19'h40144, 8'h00);
        push_cmd(1'b0, ch, 19'h00200, 8'hD2);
        push_cmd(1'b0, ch, 19'h00201, 8'h02);
        push_cmd(1'b0, ch, 19'h00202, 8'h01);
        push_cmd(1'b0, ch, 19'h00203, 8'h96);
        repeat (init_reads) push_cmd(1'b1, ch, 19'h00207, 8'h00);
    endtask

    task automatic push_ch_ok(input logic ch);
        push_attempt(ch, 1);
        push_cmd(1'b0, ch, 19'h00200, 8'hF6);
        push_cmd(1'b0, ch, 19'h00201, 8'h01);
        push_cmd(1'b0, ch, 19'h00202, 8'h03);
        push_cmd(1'b0, ch, 19'h00203, 8'h96);
        push_cmd(1'b1, ch, 19'h00207, 8'h00);
    endtask

    task automatic pulse_restart();
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
    endtask

    task automatic wait_status(input string tag);
        int cyc;
        cyc = 0;
        while (!(!busy_a && (done_a | fail_a) == 2'b11) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_in_time"}, 32'(cyc < 5000), 32'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; lock_a = 1'b0; lock_b = 1'b0; restart_a = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read",  32'(rd_a),    32'd0);
        check("rst_write", 32'(wr_a),    32'd0);
        check("rst_addr",  32'(addr_a),  32'd0);
        check("rst_wdata", 32'(wdata_a), 32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_fail",  32'(fail_a),  32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        rst = 1'b0;

        // Zero-wait bring-up of both channels.
        push_ch_ok(1'b0); push_ch_ok(1'b1);
        lock_a = 1'b1;
        wait_status("t1");
        check("t1_done", 32'(done_a), 32'd3);
        check("t1_fail", 32'(fail_a), 32'd0);
        check("t1_busy", 32'(busy_a), 32'd0);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Restart from DONE clears status at once and replays the same command log.
        push_ch_ok(1'b0); push_ch_ok(1'b1);
        pulse_restart();
        check("t6_clear", 32'(done_a), 32'd0);
        wait_status("t6");
        check("t6_done", 32'(done_a), 32'd3);
        check("t6_queue", 32'(exp_q.size()), 32'd0);

        // Five-cycle stall on every access.
        stall_n = 5;
        push_ch_ok(1'b0); push_ch_ok(1'b1);
        pulse_restart();
        wait_status("t2");
        check("t2_done", 32'(done_a), 32'd3);
        check("t2_fail", 32'(fail_a), 32'd0);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // ch1 adaptation never completes: three attempts of eight polls, then fail.
        stall_n = 0; fail_ch1 = 1'b1;
        push_ch_ok(1'b0);
        repeat (3) push_attempt(1'b1, 8);
        pulse_restart();
        wait_status("t3");
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_fail", 32'(fail_a), 32'd2);
        check("t3_queue", 32'(exp_q.size()), 32'd0);
        fail_ch1 = 1'b0;

        // Lock lost during a stalled ch1 INIT_POLL read.
        stall_n = 20;
        push_ch_ok(1'b0); push_attempt(1'b1, 1);
        pulse_restart();
        cyc = 0;
        while (!(rd_a && addr_a == {1'b1, 19'h00207}) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_reach_poll", 32'(cyc < 3000), 32'd1);
        lock_a = 1'b0;
        repeat (8) @(negedge clk);
        check("t4_read_held", 32'(rd_a), 32'd1);
        check("t4_done_clr", 32'(done_a), 32'd0);
        repeat (40) @(negedge clk);
        check("t4_idle_bus", 32'({rd_a, wr_a}), 32'd0);
        check("t4_busy", 32'(busy_a), 32'd0);
        check("t4_fail_clr", 32'(fail_a), 32'd0);
        check("t4_queue", 32'(exp_q.size()), 32'd0);
        stall_n = 0;
        push_ch_ok(1'b0); push_ch_ok(1'b1);
        lock_a = 1'b1;
        wait_status("t4_relock");
        check("t4_relock_done", 32'(done_a), 32'd3);
        check("t4_relock_queue", 32'(exp_q.size()), 32'd0);

        // No continuous adaptation build.
        lock_b = 1'b1;
        cyc = 0;
        while (!(done_b == 2'b11 && !busy_b) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_in_time", 32'(cyc < 2000), 32'd1);
        check("t5_done", 32'(done_b), 32'd3);
        check("t5_fail", 32'(fail_b), 32'd0);
        check("t5_f6_writes", 32'(nf6_b), 32'd0);
        check("t5_writes", 32'(nwr_b), 32'd10);
        check("t5_reads", 32'(nrd_b), 32'd4);

        // Reset during a stalled command drops the strobe on the next edge.
        stall_n = 20;
        pulse_restart();
        cyc = 0;
        while (!(rd_a || wr_a) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_cmd_seen", 32'(cyc < 100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_strobe", 32'({rd_a, wr_a}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
